// File: rtl/sync_adder_pipe.sv
// sync_adder_pipe: pipelined WIDTH-bit add/subtract, one CHUNK-bit ripple slice per stage.
// Define SYNC_ADDER_SAT_EN to saturate sum on signed overflow.
module sync_adder_pipe #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ce,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             out_valid
);
  localparam int NSTG = WIDTH / CHUNK;
  logic [WIDTH-1:0] beff;
  logic             ceff;
  logic [NSTG-1:0]  vld;
  logic [NSTG-1:0]  sbp;
  logic [NSTG-1:0]  cr;
  logic [WIDTH-1:0] raw;
  logic             ovf_raw;
  assign beff = b ^ {WIDTH{sub}};
  assign ceff = cin ^ sub;
  // valid and sub flags travel alongside the op so cout can be un-inverted at the end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      vld <= '0;
      sbp <= '0;
    end else if (ce) begin
      vld[0] <= in_valid;
      sbp[0] <= sub;
      for (int j = 1; j < NSTG; j++) begin
        vld[j] <= vld[j-1];
        sbp[j] <= sbp[j-1];
      end
    end
  for (genvar k = 0; k < NSTG; k++) begin : g_stg
    localparam int D = NSTG - k;
    logic [CHUNK-1:0] ak, bk;
    logic             ck;
    logic [CHUNK:0]   t;
    logic [CHUNK-1:0] q [D];
    logic             c_q;
    if (k == 0) begin : g_in
      assign ak = a[CHUNK-1:0];
      assign bk = beff[CHUNK-1:0];
      assign ck = ceff;
    end else begin : g_skew
      logic [CHUNK-1:0] sa [k];
      logic [CHUNK-1:0] sb [k];
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
          for (int j = 0; j < k; j++) begin
            sa[j] <= '0;
            sb[j] <= '0;
          end
        end else if (ce) begin
          sa[0] <= a[k*CHUNK +: CHUNK];
          sb[0] <= beff[k*CHUNK +: CHUNK];
          for (int j = 1; j < k; j++) begin
            sa[j] <= sa[j-1];
            sb[j] <= sb[j-1];
          end
        end
      assign ak = sa[k-1];
      assign bk = sb[k-1];
      assign ck = cr[k-1];
    end
    assign t = {1'b0, ak} + {1'b0, bk} + {{CHUNK{1'b0}}, ck};
    // q[0] is the stage register; the rest de-skew this chunk to line up with the MSB chunk
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        c_q <= 1'b0;
        for (int j = 0; j < D; j++) q[j] <= '0;
      end else if (ce) begin
        c_q  <= t[CHUNK];
        q[0] <= t[CHUNK-1:0];
        for (int j = 1; j < D; j++) q[j] <= q[j-1];
      end
    assign cr[k] = c_q;
    assign raw[k*CHUNK +: CHUNK] = q[D-1];
    if (k == NSTG - 1) begin : g_ovf
      logic o_q;
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) o_q <= 1'b0;
        else if (ce) o_q <= ak[CHUNK-1] ^ bk[CHUNK-1] ^ t[CHUNK-1] ^ t[CHUNK];
      assign ovf_raw = o_q;
    end
  end
  assign out_valid = vld[NSTG-1];
  assign cout      = cr[NSTG-1] ^ sbp[NSTG-1];
  assign ovf       = ovf_raw;
`ifdef SYNC_ADDER_SAT_EN
  // on overflow the raw MSB carry-out is the sign of the true result
  assign sum = ovf_raw ? {cr[NSTG-1], {(WIDTH-1){~cr[NSTG-1]}}} : raw;
`else
  assign sum = raw;
`endif
endmodule

// File: tb/tb_sync_adder_pipe.sv
// tb_sync_adder_pipe: randomized and directed checks of sync_adder_pipe against an arithmetic model.
module tb_sync_adder_pipe;
  localparam int W = 8;
  localparam int C = 2;
  localparam int N = W / C;
  logic clk = 1'b0, rst_n = 1'b0, ce = 1'b0, in_valid = 1'b0, cin = 1'b0, sub = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic [W-1:0] sum;
  logic cout, ovf, out_valid;
  int total = 0, bad = 0;
  typedef struct packed {logic v; logic [W-1:0] s; logic c; logic o;} res_t;
  res_t m [N];
  logic [W-1:0] held;

  sync_adder_pipe #(.WIDTH(W), .CHUNK(C)) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .in_valid(in_valid), .a(a), .b(b),
    .cin(cin), .sub(sub), .sum(sum), .cout(cout), .ovf(ovf), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic res_t ref_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, input logic sb);
    res_t r;
    int u, s, sx, sy;
    sx = int'($signed(x));
    sy = int'($signed(y));
    u = sb ? int'(x) - int'(y) - int'(ci) : int'(x) + int'(y) + int'(ci);
    s = sb ? sx - sy - int'(ci) : sx + sy + int'(ci);
    r.v = 1'b1;
    r.s = u[W-1:0];
    r.c = sb ? (u < 0) : (u > (1 << W) - 1);
    r.o = (s > (1 << (W-1)) - 1) || (s < -(1 << (W-1)));
`ifdef SYNC_ADDER_SAT_EN
    if (r.o) r.s = (s > 0) ? {1'b0, {(W-1){1'b1}}} : {1'b1, {(W-1){1'b0}}};
`endif
    return r;
  endfunction

  task automatic clear_model();
    for (int i = 0; i < N; i++) m[i] = '0;
  endtask

  task automatic cyc();
    @(posedge clk);
    if (rst_n && ce) begin
      for (int i = N - 1; i > 0; i--) m[i] = m[i-1];
      m[0] = in_valid ? ref_op(a, b, cin, sub) : res_t'(0);
    end
    #1;
    chk("valid", out_valid, m[N-1].v);
    if (m[N-1].v) begin
      chk("sum", sum, m[N-1].s);
      chk("cout", cout, m[N-1].c);
      chk("ovf", ovf, m[N-1].o);
    end
  endtask

  task automatic op(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, input logic sb);
    a = x; b = y; cin = ci; sub = sb; in_valid = 1'b1;
    cyc();
    in_valid = 1'b0;
  endtask

  initial begin
    clear_model();
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);
    ce = 1'b1;
    in_valid = 1'b1; a = 8'd9; b = 8'd9;
    cyc();
    cyc();
    chk("rst_hold_sum", sum, 0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    cyc();
    chk("rel_valid", out_valid, 0);
    // latency
    op(8'd15, 8'd15, 1'b0, 1'b0);
    repeat (2) begin
      cyc();
      chk("lat_early", out_valid, 0);
    end
    cyc();
    chk("lat_valid", out_valid, 1);
    chk("lat_sum", sum, 30);
    chk("lat_cout", cout, 0);
    chk("lat_ovf", ovf, 0);
    cyc();
    chk("lat_drop", out_valid, 0);
    // back-to-back
    op(8'd170, 8'd85, 1'b1, 1'b0);
    op(8'd255, 8'd255, 1'b1, 1'b0);
    op(8'd1, 8'd1, 1'b1, 1'b0);
    cyc();
    chk("b2b0_sum", sum, 0);
    chk("b2b0_cout", cout, 1);
    cyc();
    chk("b2b1_sum", sum, 255);
    chk("b2b1_cout", cout, 1);
    cyc();
    chk("b2b2_sum", sum, 3);
    chk("b2b2_cout", cout, 0);
    chk("b2b2_valid", out_valid, 1);
    // subtract and overflow
    op(8'd5, 8'd7, 1'b0, 1'b1);
    op(8'd127, 8'd1, 1'b0, 1'b0);
    op(8'd128, 8'd255, 1'b0, 1'b0);
    cyc();
    chk("sub_sum", sum, 254);
    chk("sub_cout", cout, 1);
    chk("sub_ovf", ovf, 0);
    cyc();
    chk("ovf1_ovf", ovf, 1);
`ifdef SYNC_ADDER_SAT_EN
    chk("ovf1_sum", sum, 127);
`else
    chk("ovf1_sum", sum, 128);
`endif
    cyc();
    chk("ovf2_ovf", ovf, 1);
`ifdef SYNC_ADDER_SAT_EN
    chk("ovf2_sum", sum, 128);
`else
    chk("ovf2_sum", sum, 127);
`endif
    cyc();
    // stall mid-flight
    op(8'd15, 8'd15, 1'b0, 1'b0);
    cyc();
    held = sum;
    ce = 1'b0;
    a = 8'd200; b = 8'd100; in_valid = 1'b1;
    repeat (3) begin
      cyc();
      chk("stall_sum", sum, held);
      chk("stall_valid", out_valid, 0);
    end
    in_valid = 1'b0;
    ce = 1'b1;
    cyc();
    chk("stall_early", out_valid, 0);
    cyc();
    chk("stall_valid4", out_valid, 1);
    chk("stall_sum4", sum, 30);
    // asynchronous reset mid-flight
    op(8'd40, 8'd2, 1'b0, 1'b0);
    op(8'd77, 8'd33, 1'b1, 1'b0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_sum", sum, 0);
    clear_model();
    @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (3) begin
      cyc();
      chk("flush_valid", out_valid, 0);
    end
    op(8'd100, 8'd27, 1'b0, 1'b0);
    repeat (3) cyc();
    chk("post_valid", out_valid, 1);
    chk("post_sum", sum, 127);
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      ce = ($urandom_range(0, 9) < 8);
      in_valid = ($urandom_range(0, 9) < 7);
      a = W'($urandom);
      b = W'($urandom);
      if ($urandom_range(0, 7) == 0) a = {W{1'b1}};
      if ($urandom_range(0, 7) == 0) b = {1'b1, {(W-1){1'b0}}};
      cin = 1'($urandom);
      sub = 1'($urandom);
      cyc();
    end
    in_valid = 1'b0;
    ce = 1'b1;
    repeat (N) cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
